datapath_core: RTL and testbench
================================

DATAPATH_CORE -- requirements
Module: datapath_core

Interface
REQ-001 Parameter DW, default 8, data, register and bus width in bits.
REQ-002 Parameter AW, default 8, instruction and data memory address width in bits.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 write_en  in  13  register load strobes, bit12..0 = ARB, AR, PC, DR, IR, R, TR, AC, R1, R2, Ri, Rj, Rk.
REQ-006 bus_ld  in  4  bus source select (see REQ-015).
REQ-007 inc  in  2  increment command: 00 none, 01 PC, 10 AC, 11 none.
REQ-008 alu_mode  in  4  ALU operation applied on AC load.
REQ-009 clr  in  3  synchronous clears: bit2 AC, bit1 TR, bit0 PC.
REQ-010 dm_wr  in  1  data memory write request.
REQ-011 im_rdata, dm_rdata  in  DW each  instruction and data memory read data (combinational memories).
REQ-012 im_addr  out  AW  = PC; dm_addr  out  AW  = AR; dm_bank  out  AW  = ARB.
REQ-013 dm_we  out  1  = dm_wr; dm_wdata  out  DW  = current bus value.
REQ-014 ir  out  8  IR register; z  out  1  registered zero flag of AC; bus_out  out  DW  current bus (debug).

Function
REQ-015 Bus mux, combinational: 0 im_rdata, 1 dm_rdata, 2 PC, 3 DR, 4 R, 5 AC, 6 TR, 7 R1, 8 R2, 9 Ri, 10 Rj, 11 Rk, 12-15 zero; PC/AR/ARB zero-extended or truncated to DW/AW.
REQ-016 Every register other than AC whose write_en bit is 1 loads the bus value at the rising edge; multiple bits may be set in one cycle (e.g. ARB and AR both load).
REQ-017 AC load (write_en[5]) takes alu_result: mode 0 AC+bus, 1 AC-bus, 2 low DW bits of AC*bus, 5 pass bus, all other codes pass bus.
REQ-018 Add, sub and mult results are truncated to DW bits, wrapping modulo 2^DW; there is no carry or overflow flag.
REQ-019 inc=01 increments PC by 1 and inc=10 increments AC by 1, both wrapping from 2^width-1 to 0.
REQ-020 Per-register priority: clr > write_en load > inc. Example: clr[2] with write_en[5] gives AC=0; write_en[10] with inc=01 gives PC=bus.
REQ-021 z is updated on every cycle in which AC changes through clear, load or increment, to (next AC == 0); otherwise z holds.
REQ-022 Single-cycle latency: a value loaded at edge N is visible on the bus, ir and the address outputs after edge N; z is valid in the same cycle as the new AC.
REQ-023 dm_we/dm_wdata are pure pass-through (no registering); memory captures on the same edge, so a write presents the bus value during the dm_wr cycle.
REQ-024 The ALU reads the pre-edge AC and bus values; a simultaneous AC load sourced from AC (bus_ld=5, mode 0) yields 2*AC.
REQ-025 Unused write_en combinations, inc=11 and unlisted alu_mode codes cause no error state and no side effects beyond REQ-016/017.

Reset
REQ-026 rst_n low asynchronously clears ARB, AR, PC, DR, IR, R, TR, AC, R1, R2, Ri, Rj and Rk to 0 and sets z to 1, regardless of clk.
REQ-027 Assertion mid-operation discards any in-flight load, increment or write; outputs reflect reset values immediately; first load occurs on the first rising edge after rst_n high.

Verification
REQ-028 Reset: pulse rst_n low between edges -> all registers 0, z=1, im_addr=0, dm_we follows dm_wr.
REQ-029 Fetch: im_rdata=0x0B, inc=01, write_en DR then IR from bus_ld=3 -> PC=1, ir=0x0B after 2 edges.
REQ-030 ALU: AC=200, R1=100, bus_ld=7, mode 0, write_en[5] -> AC=44, z=0; mode 1 with R1=44 -> AC=0, z=1.
REQ-031 Multiply: AC=16, R=17, mode 2 -> AC=0x10 (272 mod 256); inc=10 with AC=255 -> AC=0, z=1.
REQ-032 Priority: clr=111 with write_en all ones and inc=01 -> AC=TR=PC=0; other registers load bus.
REQ-033 Store: AR=0x20, bus_ld=5, AC=0x7F, dm_wr=1 -> dm_we=1, dm_addr=0x20, dm_wdata=0x7F in the same cycle.

Source files
------------

// File: rtl/datapath_core.sv
// datapath_core: register-file datapath with a 16-way source bus, a small ALU
// feeding the accumulator, and PC/AC incrementers. The bus value is also the
// data-memory write data, so a store presents the selected register directly.
module datapath_core #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [12:0]   write_en,
  input  logic [3:0]    bus_ld,
  input  logic [1:0]    inc,
  input  logic [3:0]    alu_mode,
  input  logic [2:0]    clr,
  input  logic          dm_wr,
  input  logic [DW-1:0] im_rdata,
  input  logic [DW-1:0] dm_rdata,
  output logic [AW-1:0] im_addr,
  output logic [AW-1:0] dm_addr,
  output logic [AW-1:0] dm_bank,
  output logic          dm_we,
  output logic [DW-1:0] dm_wdata,
  output logic [7:0]    ir,
  output logic          z,
  output logic [DW-1:0] bus_out
);

  // Load-strobe bit positions within write_en
  localparam int WE_ARB = 12;
  localparam int WE_AR  = 11;
  localparam int WE_PC  = 10;
  localparam int WE_DR  = 9;
  localparam int WE_IR  = 8;
  localparam int WE_R   = 7;
  localparam int WE_TR  = 6;
  localparam int WE_AC  = 5;
  localparam int WE_R1  = 4;
  localparam int WE_R2  = 3;
  localparam int WE_RI  = 2;
  localparam int WE_RJ  = 1;
  localparam int WE_RK  = 0;

  typedef enum logic [3:0] {
    SRC_IM  = 4'd0,
    SRC_DM  = 4'd1,
    SRC_PC  = 4'd2,
    SRC_DR  = 4'd3,
    SRC_R   = 4'd4,
    SRC_AC  = 4'd5,
    SRC_TR  = 4'd6,
    SRC_R1  = 4'd7,
    SRC_R2  = 4'd8,
    SRC_RI  = 4'd9,
    SRC_RJ  = 4'd10,
    SRC_RK  = 4'd11
  } busSrcE;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2
  } aluModeE;

  logic [AW-1:0]   r_arb, r_ar, r_pc;
  logic [DW-1:0]   r_dr, r_r, r_tr, r_ac, r_r1, r_r2, r_ri, r_rj, r_rk;
  logic [7:0]      r_ir;
  logic            r_z;

  logic [DW-1:0]   w_bus;
  logic [DW-1:0]   w_pcOnBus;
  logic [AW-1:0]   w_busToAddr;
  logic [7:0]      w_busToIr;
  logic [2*DW-1:0] w_prod;
  logic [DW-1:0]   w_aluResult;
  logic [DW-1:0]   w_acNext;
  logic            w_acTouched;

  // Width adapters between the DW-wide bus and the AW-wide / 8-bit registers
  if (AW >= DW) begin : g_pcTrunc
    assign w_pcOnBus = r_pc[DW-1:0];
  end else begin : g_pcExt
    assign w_pcOnBus = {{(DW-AW){1'b0}}, r_pc};
  end

  if (DW >= AW) begin : g_addrTrunc
    assign w_busToAddr = w_bus[AW-1:0];
  end else begin : g_addrExt
    assign w_busToAddr = {{(AW-DW){1'b0}}, w_bus};
  end

  if (DW >= 8) begin : g_irTrunc
    assign w_busToIr = w_bus[7:0];
  end else begin : g_irExt
    assign w_busToIr = {{(8-DW){1'b0}}, w_bus};
  end

  // Bus source multiplexer; codes 12-15 drive zero
  always_comb begin
    w_bus = '0;
    case (busSrcE'(bus_ld))
      SRC_IM: w_bus = im_rdata;
      SRC_DM: w_bus = dm_rdata;
      SRC_PC: w_bus = w_pcOnBus;
      SRC_DR: w_bus = r_dr;
      SRC_R:  w_bus = r_r;
      SRC_AC: w_bus = r_ac;
      SRC_TR: w_bus = r_tr;
      SRC_R1: w_bus = r_r1;
      SRC_R2: w_bus = r_r2;
      SRC_RI: w_bus = r_ri;
      SRC_RJ: w_bus = r_rj;
      SRC_RK: w_bus = r_rk;
      default: w_bus = '0;
    endcase
  end

  assign w_prod = {{DW{1'b0}}, r_ac} * {{DW{1'b0}}, w_bus};

  // ALU on pre-edge AC and bus; results wrap to DW bits, unknown modes pass the bus
  always_comb begin
    w_aluResult = w_bus;
    case (aluModeE'(alu_mode))
      ALU_ADD: w_aluResult = r_ac + w_bus;
      ALU_SUB: w_aluResult = r_ac - w_bus;
      ALU_MUL: w_aluResult = w_prod[DW-1:0];
      default: w_aluResult = w_bus;
    endcase
  end

  // Next AC with clear > load > increment; flags whether z must be refreshed
  always_comb begin
    w_acNext    = r_ac;
    w_acTouched = 1'b0;
    if (clr[2]) begin
      w_acNext    = '0;
      w_acTouched = 1'b1;
    end else if (write_en[WE_AC]) begin
      w_acNext    = w_aluResult;
      w_acTouched = 1'b1;
    end else if (inc == 2'b10) begin
      w_acNext    = r_ac + DW'(1);
      w_acTouched = 1'b1;
    end
  end

  // Register file update: async reset, then per-register clear > load > increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arb <= '0;
      r_ar  <= '0;
      r_pc  <= '0;
      r_dr  <= '0;
      r_ir  <= '0;
      r_r   <= '0;
      r_tr  <= '0;
      r_ac  <= '0;
      r_r1  <= '0;
      r_r2  <= '0;
      r_ri  <= '0;
      r_rj  <= '0;
      r_rk  <= '0;
      r_z   <= 1'b1;
    end else begin
      if (write_en[WE_ARB]) r_arb <= w_busToAddr;
      if (write_en[WE_AR])  r_ar  <= w_busToAddr;
      if (clr[0])                r_pc <= '0;
      else if (write_en[WE_PC])  r_pc <= w_busToAddr;
      else if (inc == 2'b01)     r_pc <= r_pc + AW'(1);
      if (write_en[WE_DR])  r_dr  <= w_bus;
      if (write_en[WE_IR])  r_ir  <= w_busToIr;
      if (write_en[WE_R])   r_r   <= w_bus;
      if (clr[1])                r_tr <= '0;
      else if (write_en[WE_TR])  r_tr <= w_bus;
      r_ac <= w_acNext;
      if (w_acTouched)      r_z   <= (w_acNext == '0);
      if (write_en[WE_R1])  r_r1  <= w_bus;
      if (write_en[WE_R2])  r_r2  <= w_bus;
      if (write_en[WE_RI])  r_ri  <= w_bus;
      if (write_en[WE_RJ])  r_rj  <= w_bus;
      if (write_en[WE_RK])  r_rk  <= w_bus;
    end
  end

  assign im_addr  = r_pc;
  assign dm_addr  = r_ar;
  assign dm_bank  = r_arb;
  assign dm_we    = dm_wr;
  assign dm_wdata = w_bus;
  assign ir       = r_ir;
  assign z        = r_z;
  assign bus_out  = w_bus;

endmodule

// File: tb/tb_datapath_core.sv
// tb_datapath_core: directed vector table, hand-written reset/store sequences,
// and a randomized run against a behavioural model of the datapath.
module tb_datapath_core;

  logic        clk;
  logic        rst_n;
  logic [12:0] write_en;
  logic [3:0]  bus_ld;
  logic [1:0]  inc;
  logic [3:0]  alu_mode;
  logic [2:0]  clr;
  logic        dm_wr;
  logic [7:0]  im_rdata;
  logic [7:0]  dm_rdata;
  logic [7:0]  im_addr;
  logic [7:0]  dm_addr;
  logic [7:0]  dm_bank;
  logic        dm_we;
  logic [7:0]  dm_wdata;
  logic [7:0]  ir;
  logic        z;
  logic [7:0]  bus_out;

  int testsRun;
  int testsFailed;

  // Model state: index = write_en bit (12 ARB .. 0 Rk)
  int mReg [13];
  int mZ;

  datapath_core #(.DW(8), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .bus_ld(bus_ld),
    .inc(inc), .alu_mode(alu_mode), .clr(clr), .dm_wr(dm_wr),
    .im_rdata(im_rdata), .dm_rdata(dm_rdata), .im_addr(im_addr),
    .dm_addr(dm_addr), .dm_bank(dm_bank), .dm_we(dm_we),
    .dm_wdata(dm_wdata), .ir(ir), .z(z), .bus_out(bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] we;
    logic [3:0]  busLd;
    logic [1:0]  incCmd;
    logic [3:0]  mode;
    logic [2:0]  clrCmd;
    logic [7:0]  im;
    logic [3:0]  peek;
    int          expPeek;
    int          expPc;
    int          expIr;
    int          expAr;
    int          expZ;
  } vecT;

  vecT vecs [19];

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [12:0] we, input logic [3:0] bl,
                               input logic [1:0] ic, input logic [3:0] md,
                               input logic [2:0] cl, input logic dw,
                               input logic [7:0] imr, input logic [7:0] dmr);
    write_en = we;
    bus_ld   = bl;
    inc      = ic;
    alu_mode = md;
    clr      = cl;
    dm_wr    = dw;
    im_rdata = imr;
    dm_rdata = dmr;
  endtask

  function automatic int modelBus(input int bl, input int imr, input int dmr);
    case (bl)
      0: return imr;
      1: return dmr;
      2: return mReg[10];
      3: return mReg[9];
      4: return mReg[7];
      5: return mReg[5];
      6: return mReg[6];
      7: return mReg[4];
      8: return mReg[3];
      9: return mReg[2];
      10: return mReg[1];
      11: return mReg[0];
      default: return 0;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 13; i++) mReg[i] = 0;
    mZ = 1;
  endtask

  task automatic modelStep(input logic [12:0] we, input int bl, input int ic,
                           input int md, input logic [2:0] cl, input int imr, input int dmr);
    int busV;
    int aluV;
    busV = modelBus(bl, imr, dmr);
    case (md)
      0: aluV = (mReg[5] + busV) % 256;
      1: aluV = (mReg[5] - busV + 256) % 256;
      2: aluV = (mReg[5] * busV) % 256;
      default: aluV = busV;
    endcase
    for (int i = 0; i < 13; i++)
      if (we[i]) mReg[i] = (i == 5) ? aluV : busV;
    if (ic == 1 && !we[10]) mReg[10] = (mReg[10] + 1) % 256;
    if (ic == 2 && !we[5])  mReg[5]  = (mReg[5] + 1) % 256;
    if (cl[2]) mReg[5]  = 0;
    if (cl[1]) mReg[6]  = 0;
    if (cl[0]) mReg[10] = 0;
    if (cl[2] || we[5] || ic == 2) mZ = (mReg[5] == 0) ? 1 : 0;
  endtask

  task automatic idleInputs();
    applyStimulus(13'h0, 4'd0, 2'b00, 4'd0, 3'b000, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    idleInputs();
    rst_n = 1'b0;

    //           we        bl  inc   md  clr     im     peek expPeek pc    ir    ar    z
    vecs[0]  = '{13'h0200, 0, 2'b01, 0, 3'b000, 8'h0B, 3,  'h0B,  1,    0,    0,    1};
    vecs[1]  = '{13'h0100, 3, 2'b00, 0, 3'b000, 8'h00, 2,  1,     1,    'h0B, 0,    1};
    vecs[2]  = '{13'h0020, 0, 2'b00, 5, 3'b000, 8'd200,5,  200,   1,    'h0B, 0,    0};
    vecs[3]  = '{13'h0010, 0, 2'b00, 0, 3'b000, 8'd100,7,  100,   1,    'h0B, 0,    0};
    vecs[4]  = '{13'h0020, 7, 2'b00, 0, 3'b000, 8'h00, 5,  44,    1,    'h0B, 0,    0};
    vecs[5]  = '{13'h0010, 0, 2'b00, 0, 3'b000, 8'd44, 7,  44,    1,    'h0B, 0,    0};
    vecs[6]  = '{13'h0020, 7, 2'b00, 1, 3'b000, 8'h00, 5,  0,     1,    'h0B, 0,    1};
    vecs[7]  = '{13'h0020, 0, 2'b00, 5, 3'b000, 8'd16, 5,  16,    1,    'h0B, 0,    0};
    vecs[8]  = '{13'h0080, 0, 2'b00, 0, 3'b000, 8'd17, 4,  17,    1,    'h0B, 0,    0};
    vecs[9]  = '{13'h0020, 4, 2'b00, 2, 3'b000, 8'h00, 5,  'h10,  1,    'h0B, 0,    0};
    vecs[10] = '{13'h0020, 0, 2'b00, 7, 3'b000, 8'd255,5,  255,   1,    'h0B, 0,    0};
    vecs[11] = '{13'h0000, 0, 2'b10, 0, 3'b000, 8'h00, 5,  0,     1,    'h0B, 0,    1};
    vecs[12] = '{13'h0020, 0, 2'b00, 3, 3'b000, 8'h21, 5,  'h21,  1,    'h0B, 0,    0};
    vecs[13] = '{13'h0020, 5, 2'b00, 0, 3'b000, 8'h00, 5,  'h42,  1,    'h0B, 0,    0};
    vecs[14] = '{13'h1FFF, 0, 2'b01, 0, 3'b111, 8'h5A, 6,  0,     0,    'h5A, 'h5A, 1};
    vecs[15] = '{13'h0400, 0, 2'b01, 0, 3'b000, 8'h30, 2,  'h30,  'h30, 'h5A, 'h5A, 1};
    vecs[16] = '{13'h0020, 0, 2'b00, 5, 3'b000, 8'h77, 5,  'h77,  'h30, 'h5A, 'h5A, 0};
    vecs[17] = '{13'h0020, 0, 2'b00, 5, 3'b100, 8'h77, 5,  0,     'h30, 'h5A, 'h5A, 1};
    vecs[18] = '{13'h0000, 0, 2'b11, 0, 3'b000, 8'h00, 2,  'h30,  'h30, 'h5A, 'h5A, 1};

    // Reset pulse between edges, then reset-state checks
    #12;
    dm_wr = 1'b1;
    bus_ld = 4'd5;
    #1;
    checkOutput("reset_z", z, 1);
    checkOutput("reset_im_addr", im_addr, 0);
    checkOutput("reset_ir", ir, 0);
    checkOutput("reset_bus_ac", bus_out, 0);
    checkOutput("reset_dm_we_follow", dm_we, 1);
    rst_n = 1'b1;
    idleInputs();

    // Directed vector table
    for (int v = 0; v < 19; v++) begin
      applyStimulus(vecs[v].we, vecs[v].busLd, vecs[v].incCmd, vecs[v].mode,
                    vecs[v].clrCmd, 1'b0, vecs[v].im, 8'h00);
      @(posedge clk);
      #1;
      applyStimulus(13'h0, vecs[v].peek, 2'b00, 4'd0, 3'b000, 1'b0, vecs[v].im, 8'h00);
      #1;
      checkOutput($sformatf("vec%0d_peek", v), bus_out, vecs[v].expPeek);
      checkOutput($sformatf("vec%0d_pc", v), im_addr, vecs[v].expPc);
      checkOutput($sformatf("vec%0d_ir", v), ir, vecs[v].expIr);
      checkOutput($sformatf("vec%0d_ar", v), dm_addr, vecs[v].expAr);
      checkOutput($sformatf("vec%0d_z", v), z, vecs[v].expZ);
    end

    // Mid-operation async reset discards pending loads and acts immediately
    applyStimulus(13'h0020, 4'd0, 2'b00, 4'd5, 3'b000, 1'b0, 8'h55, 8'h00);
    @(posedge clk);
    #1;
    applyStimulus(13'h1FFF, 4'd0, 2'b01, 4'd5, 3'b000, 1'b1, 8'h99, 8'h00);
    #1;
    rst_n = 1'b0;
    #1;
    bus_ld = 4'd5;
    #1;
    checkOutput("midrst_ac", bus_out, 0);
    checkOutput("midrst_z", z, 1);
    checkOutput("midrst_pc", im_addr, 0);
    checkOutput("midrst_ir", ir, 0);
    checkOutput("midrst_bank", dm_bank, 0);
    bus_ld = 4'd0;
    @(posedge clk);
    #1;
    checkOutput("heldrst_ir", ir, 0);
    checkOutput("heldrst_ar", dm_addr, 0);
    rst_n = 1'b1;
    applyStimulus(13'h0100, 4'd0, 2'b00, 4'd0, 3'b000, 1'b0, 8'h3C, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("postrst_first_load_ir", ir, 'h3C);

    // Store: AR and AC set, then dm_wr presents bus with AC in the same cycle
    applyStimulus(13'h0800, 4'd0, 2'b00, 4'd0, 3'b000, 1'b0, 8'h20, 8'h00);
    @(posedge clk);
    #1;
    applyStimulus(13'h0020, 4'd0, 2'b00, 4'd5, 3'b000, 1'b0, 8'h7F, 8'h00);
    @(posedge clk);
    #1;
    applyStimulus(13'h0000, 4'd5, 2'b00, 4'd0, 3'b000, 1'b1, 8'h00, 8'h00);
    #1;
    checkOutput("store_dm_we", dm_we, 1);
    checkOutput("store_dm_addr", dm_addr, 'h20);
    checkOutput("store_dm_wdata", dm_wdata, 'h7F);
    dm_wr = 1'b0;
    #1;
    checkOutput("store_dm_we_off", dm_we, 0);

    // Randomized run against the behavioural model
    idleInputs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    modelReset();
    for (int n = 0; n < 400; n++) begin
      logic [12:0] rWe;
      logic [3:0]  rBl;
      logic [1:0]  rInc;
      logic [3:0]  rMd;
      logic [2:0]  rClr;
      logic        rDw;
      logic [7:0]  rIm;
      logic [7:0]  rDm;
      @(negedge clk);
      rWe  = 13'($urandom) & 13'($urandom);
      rBl  = 4'($urandom_range(0, 15));
      rInc = 2'($urandom_range(0, 3));
      rMd  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      rClr = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      rDw  = 1'($urandom);
      rIm  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      rDm  = 8'($urandom);
      applyStimulus(rWe, rBl, rInc, rMd, rClr, rDw, rIm, rDm);
      #1;
      checkOutput("rnd_bus", bus_out, modelBus(rBl, rIm, rDm));
      checkOutput("rnd_wdata", dm_wdata, modelBus(rBl, rIm, rDm));
      checkOutput("rnd_dm_we", dm_we, rDw);
      modelStep(rWe, rBl, rInc, rMd, rClr, rIm, rDm);
      @(posedge clk);
      #1;
      checkOutput("rnd_pc", im_addr, mReg[10]);
      checkOutput("rnd_ar", dm_addr, mReg[11]);
      checkOutput("rnd_arb", dm_bank, mReg[12]);
      checkOutput("rnd_ir", ir, mReg[8]);
      checkOutput("rnd_z", z, mZ);
      bus_ld = 4'd5;
      #1;
      checkOutput("rnd_ac", bus_out, mReg[5]);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
